// File: rtl/pwm_event_gen_pkg.sv
// Shared types and defaults for the PWM edge-event generator.
`ifndef PWM_WIDTH
`define PWM_WIDTH 8
`endif
`ifndef PWM_EVT_DEC_W
`define PWM_EVT_DEC_W 4
`endif

package pwm_event_gen_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_sel_t;

  localparam int unsigned DefaultDecW = `PWM_EVT_DEC_W;

  // Bit 0 of the select enables rising edges, bit 1 enables falling edges.
  function automatic logic edgeQualifies(edge_sel_t sel, logic rise, logic fall);
    return (sel[0] & rise) | (sel[1] & fall);
  endfunction

endpackage

// File: rtl/pwm_event_gen_chan.sv
// One channel: input sampling, edge detect, decimation counter, event pulse and sticky flag.
module pwm_event_chan
  import pwm_event_gen_pkg::*;
#(
  parameter int unsigned DEC_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             primed_i,
  input  logic             pwm_i,
  input  edge_sel_t        edge_sel_i,
  input  logic [DEC_W-1:0] decim_i,
  input  logic             flag_clr_i,
  output logic             event_o,
  output logic             flag_o
);

  logic             cur_q, prev_q;
  logic [DEC_W-1:0] cnt_q, cnt_d;
  logic             event_q, event_d;
  logic             flag_q, flag_d;
  logic             riseEdge, fallEdge, qualified;

  always_comb begin
    riseEdge  = cur_q & ~prev_q;
    fallEdge  = ~cur_q & prev_q;
    qualified = primed_i & edgeQualifies(edge_sel_i, riseEdge, fallEdge);
    cnt_d     = cnt_q;
    event_d   = 1'b0;
    if (!enable_i || (edge_sel_i == EDGE_NONE)) begin
      cnt_d = '0;
    end else if (qualified) begin
      // >= lets a decimation value lowered below the running count fire at once
      if (cnt_q >= decim_i) begin
        event_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // A set seen either on the edge that raises the pulse or while it is high beats a clear
    flag_d = event_d | event_q | (flag_q & ~flag_clr_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q   <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      event_q <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      cur_q   <= pwm_i;
      prev_q  <= cur_q;
      cnt_q   <= cnt_d;
      event_q <= event_d;
      flag_q  <= flag_d;
    end
  end

  assign event_o = event_q;
  assign flag_o  = flag_q;

endmodule

// File: rtl/pwm_event_gen.sv
// Per-channel PWM edge event generator: shared priming logic plus N_CH channel instances.
module pwm_event_gen
  import pwm_event_gen_pkg::*;
#(
  parameter int unsigned N_CH  = `PWM_WIDTH,
  parameter int unsigned DEC_W = DefaultDecW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [N_CH-1:0]       pwm_in,
  input  logic [2*N_CH-1:0]     edge_sel,
  input  logic [DEC_W*N_CH-1:0] decim,
  input  logic [N_CH-1:0]       flag_clr,
  output logic [N_CH-1:0]       event_out,
  output logic [N_CH-1:0]       event_flag
);

  logic armed_q, primed_q;

  // Edges only count once prev holds a real sample, not the reset zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q  <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      armed_q  <= 1'b1;
      primed_q <= armed_q;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : gChan
    pwm_event_chan #(
      .DEC_W(DEC_W)
    ) uChan (
      .clk       (clk),
      .reset     (reset),
      .enable_i  (enable),
      .primed_i  (primed_q),
      .pwm_i     (pwm_in[i]),
      .edge_sel_i(edge_sel_t'(edge_sel[2*i +: 2])),
      .decim_i   (decim[DEC_W*i +: DEC_W]),
      .flag_clr_i(flag_clr[i]),
      .event_o   (event_out[i]),
      .flag_o    (event_flag[i])
    );
  end

endmodule

// File: tb/tb_pwm_event_gen.sv
// Scoreboard bench for pwm_event_gen: directed scenarios followed by randomized traffic.
module tb_pwm_event_gen;

  localparam int N  = 8;
  localparam int DW = 4;

  logic            clk = 1'b0;
  logic            reset, enable;
  logic [N-1:0]    pwm_in, flag_clr, event_out, event_flag;
  logic [2*N-1:0]  edge_sel;
  logic [DW*N-1:0] decim;

  pwm_event_gen #(.N_CH(N), .DEC_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .pwm_in    (pwm_in),
    .edge_sel  (edge_sel),
    .decim     (decim),
    .flag_clr  (flag_clr),
    .event_out (event_out),
    .event_flag(event_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] evt;
    logic [N-1:0] flag;
  } exp_t;

  exp_t expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;
  bit   stimDone = 1'b0;
  int   pulseCount[N];
  int   cyc = 0;

  logic         rstV, enV;
  logic [N-1:0] pwmV, clrV;
  logic [1:0]   selV[N];
  int           decV[N];

  int edgesSinceFire[N];
  bit curL[N], prevL[N], flagM[N], evtPrevM[N];
  int nSamp;

  // Drive one cycle of inputs and push what the outputs must be after the next edge.
  task automatic applyStimulus();
    exp_t e;
    bit   fire, edgeSeen;
    @(negedge clk);
    reset    = rstV;
    enable   = enV;
    pwm_in   = pwmV;
    flag_clr = clrV;
    for (int i = 0; i < N; i++) begin
      edge_sel[2*i +: 2] = selV[i];
      decim[DW*i +: DW]  = decV[i][DW-1:0];
    end
    e = '0;
    for (int i = 0; i < N; i++) begin
      fire = 1'b0;
      if (rstV) begin
        edgesSinceFire[i] = 0;
        flagM[i] = 1'b0;
      end else begin
        edgeSeen = (nSamp >= 2) &&
                   ((selV[i][0] && curL[i] && !prevL[i]) ||
                    (selV[i][1] && !curL[i] && prevL[i]));
        if (!enV || selV[i] == 2'b00) begin
          edgesSinceFire[i] = 0;
        end else if (edgeSeen) begin
          if (edgesSinceFire[i] + 1 > decV[i]) begin
            fire = 1'b1;
            edgesSinceFire[i] = 0;
          end else begin
            edgesSinceFire[i]++;
          end
        end
        flagM[i] = fire || evtPrevM[i] || (flagM[i] && !clrV[i]);
      end
      evtPrevM[i] = fire;
      e.evt[i]    = fire;
      e.flag[i]   = flagM[i];
      if (rstV) begin
        prevL[i] = 1'b0;
        curL[i]  = 1'b0;
      end else begin
        prevL[i] = curL[i];
        curL[i]  = pwmV[i];
      end
    end
    nSamp = rstV ? 0 : ((nSamp < 2) ? nSamp + 1 : 2);
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus();
  endtask

  task automatic risingEdges(input int ch, input int n);
    repeat (n) begin
      pwmV[ch] = 1'b1;
      idle(2);
      pwmV[ch] = 1'b0;
      idle(2);
    end
  endtask

  task automatic zeroCounts();
    for (int i = 0; i < N; i++) pulseCount[i] = 0;
  endtask

  // Monitor: pops one expectation per clock and compares both output vectors.
  initial begin : monitor
    exp_t e;
    @(negedge clk);
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (expQ.size() == 0) begin
        if (!stimDone) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL scoreboard underflow at cycle %0d", cyc);
        end
      end else begin
        e = expQ.pop_front();
        testsRun++;
        if (event_out !== e.evt) begin
          testsFailed++;
          $display("[TB] FAIL event_out cycle %0d: got %b expected %b", cyc, event_out, e.evt);
        end
        testsRun++;
        if (event_flag !== e.flag) begin
          testsFailed++;
          $display("[TB] FAIL event_flag cycle %0d: got %b expected %b", cyc, event_flag, e.flag);
        end
        for (int i = 0; i < N; i++) if (event_out[i] === 1'b1) pulseCount[i]++;
      end
    end
  end

  initial begin : stimulus
    int total;
    reset = 1'b1; enable = 1'b0; pwm_in = '0; edge_sel = '0; decim = '0; flag_clr = '0;
    nSamp = 0;
    for (int i = 0; i < N; i++) begin
      edgesSinceFire[i] = 0; curL[i] = 0; prevL[i] = 0; flagM[i] = 0; evtPrevM[i] = 0;
      selV[i] = 2'b01; decV[i] = 0; pulseCount[i] = 0;
    end
    rstV = 1'b1; enV = 1'b1; pwmV = '1; clrV = '0;

    // Inputs held high through reset exit must not look like rising edges.
    idle(3);
    rstV = 1'b0;
    zeroCounts();
    idle(10);
    total = 0;
    for (int i = 0; i < N; i++) total += pulseCount[i];
    checkOutput("reset-high no pulses", total, 0);

    // Single rising edge, decim 0.
    pwmV = '0;
    for (int i = 0; i < N; i++) selV[i] = 2'b00;
    selV[0] = 2'b01;
    idle(4);
    zeroCounts();
    pwmV[0] = 1'b1;
    idle(6);
    checkOutput("rise decim0 pulses", pulseCount[0], 1);

    // Both edges, decim 3, eight edges.
    selV[1] = 2'b11; decV[1] = 3;
    idle(2);
    zeroCounts();
    repeat (8) begin
      pwmV[1] = ~pwmV[1];
      idle(4);
    end
    idle(4);
    checkOutput("both decim3 pulses", pulseCount[1], 2);

    // Flag clear coinciding with the pulse, then alone.
    selV[2] = 2'b01; decV[2] = 0;
    idle(2);
    pwmV[2] = 1'b1;
    idle(2);
    clrV[2] = 1'b1;
    idle(1);
    checkOutput("flag held over clr", int'(event_flag[2]), 1);
    idle(1);
    clrV[2] = 1'b0;
    idle(1);
    checkOutput("flag cleared", int'(event_flag[2]), 0);
    idle(2);

    // Disable mid-count restarts the decimation.
    selV[3] = 2'b01; decV[3] = 5;
    idle(2);
    zeroCounts();
    risingEdges(3, 3);
    enV = 1'b0;
    idle(10);
    enV = 1'b1;
    risingEdges(3, 5);
    idle(3);
    checkOutput("disable restart 5 edges", pulseCount[3], 0);
    risingEdges(3, 1);
    idle(3);
    checkOutput("disable restart 6th edge", pulseCount[3], 1);

    // Lowering decim below the running count fires on the next edge.
    selV[4] = 2'b01; decV[4] = 7;
    idle(2);
    zeroCounts();
    risingEdges(4, 4);
    checkOutput("decim7 four edges", pulseCount[4], 0);
    decV[4] = 1;
    risingEdges(4, 1);
    idle(2);
    checkOutput("lowered decim fires", pulseCount[4], 1);

    // Randomized traffic, including occasional reset and disable.
    for (int c = 0; c < 600; c++) begin
      rstV = ($urandom_range(0, 199) == 0);
      enV  = ($urandom_range(0, 19) != 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) pwmV[i] = ~pwmV[i];
        clrV[i] = ($urandom_range(0, 7) == 0);
        if (c % 40 == 0) begin
          selV[i] = 2'($urandom_range(0, 3));
          decV[i] = int'($urandom_range(0, 4));
        end
      end
      applyStimulus();
    end
    rstV = 1'b0; enV = 1'b1; clrV = '0;
    idle(3);
    stimDone = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
